// File: rtl/rattlesnake_reg_file_mp_pkg.sv
// Shared constants and FSM encoding for the multi-read-port integer register file.
package rattlesnake_reg_file_mp_pkg;

  localparam int unsigned DEFAULT_XLEN          = 32;
  localparam int unsigned DEFAULT_REG_ADDR_BITS = 5;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } rf_state_e;

endpackage

// File: rtl/rattlesnake_reg_file_mp_if.sv
// Decode/write-back facing bus of the register file; master = core side, slave = register file.
interface rattlesnake_reg_file_mp_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_BITS  = 5,
  parameter int unsigned NUM_READ_PORTS = 2
);

  logic                                    read_enable;
  logic [NUM_READ_PORTS*REG_ADDR_BITS-1:0] read_addr;
  logic                                    read_en_out;
  logic [NUM_READ_PORTS*XLEN-1:0]          read_data_out;
  logic                                    write_enable;
  logic [REG_ADDR_BITS-1:0]                write_addr;
  logic [XLEN-1:0]                         write_data_in;
  logic                                    init_busy;
  logic                                    write_dropped;

  modport master (
    output read_enable, read_addr, write_enable, write_addr, write_data_in,
    input  read_en_out, read_data_out, init_busy, write_dropped
  );

  modport slave (
    input  read_enable, read_addr, write_enable, write_addr, write_data_in,
    output read_en_out, read_data_out, init_busy, write_dropped
  );

endinterface

// File: rtl/rattlesnake_reg_file_mp_dual_port_ram.sv
// Simple dual-port block RAM: one write port, one registered read port, read-first, no reset.
module rattlesnake_reg_file_mp_dual_port_ram #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
    if (read_enable) begin
      read_data <= mem[read_addr];
    end
  end

endmodule

// File: rtl/rattlesnake_reg_file_mp.sv
// Integer register file with N replicated BRAM read ports, write-first forwarding, x0 = 0
// and a post-reset clear sequencer (BRAM contents cannot be reset directly).
module rattlesnake_reg_file_mp
  import rattlesnake_reg_file_mp_pkg::*;
#(
  parameter int unsigned XLEN           = DEFAULT_XLEN,
  parameter int unsigned REG_ADDR_BITS  = DEFAULT_REG_ADDR_BITS,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned INIT_ON_RESET  = 1
) (
  input logic                        clk,
  input logic                        reset_n,
  input logic                        sync_reset,
  rattlesnake_reg_file_mp_if.slave   bus
);

  localparam rf_state_e ResetState = (INIT_ON_RESET != 0) ? StInit : StRun;

  rf_state_e                 state_q;
  logic [REG_ADDR_BITS-1:0]  clr_cnt_q;
  logic                      read_en_out_q;
  logic                      write_dropped_q;
  logic [NUM_READ_PORTS-1:0] zero_q, zero_d;
  logic [NUM_READ_PORTS-1:0] fwd_q, fwd_d;
  logic [XLEN-1:0]           fwd_data_q;

  logic                      rd_accept;
  logic                      wr_accept;
  logic                      ram_we;
  logic [REG_ADDR_BITS-1:0]  ram_waddr;
  logic [XLEN-1:0]           ram_wdata;
  logic [REG_ADDR_BITS-1:0]  rd_addr   [NUM_READ_PORTS];
  logic [XLEN-1:0]           ram_rdata [NUM_READ_PORTS];

  assign rd_accept = (state_q == StRun) && bus.read_enable && !sync_reset;
  assign wr_accept = (state_q == StRun) && bus.write_enable && !sync_reset;

  // Shared RAM write port: the clear sequencer owns it while initialising.
  always_comb begin
    ram_we    = wr_accept;
    ram_waddr = bus.write_addr;
    ram_wdata = bus.write_data_in;
    if (state_q == StInit) begin
      ram_we    = !sync_reset;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ResetState;
      clr_cnt_q       <= '0;
      read_en_out_q   <= 1'b0;
      write_dropped_q <= 1'b0;
      zero_q          <= '0;
      fwd_q           <= '0;
      fwd_data_q      <= '0;
    end else if (sync_reset) begin
      state_q         <= ResetState;
      clr_cnt_q       <= '0;
      read_en_out_q   <= 1'b0;
      write_dropped_q <= 1'b0;
      zero_q          <= '0;
      fwd_q           <= '0;
      fwd_data_q      <= '0;
    end else begin
      read_en_out_q <= rd_accept;
      if (rd_accept) begin
        zero_q     <= zero_d;
        fwd_q      <= fwd_d;
        fwd_data_q <= bus.write_data_in;
      end
      unique case (state_q)
        StInit: begin
          if (bus.write_enable) begin
            write_dropped_q <= 1'b1;
          end
          if (clr_cnt_q == {REG_ADDR_BITS{1'b1}}) begin
            state_q   <= StRun;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= ResetState;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_port
    assign rd_addr[i] = bus.read_addr[i*REG_ADDR_BITS +: REG_ADDR_BITS];
    assign zero_d[i]  = (rd_addr[i] == '0);
    assign fwd_d[i]   = wr_accept && (bus.write_addr == rd_addr[i]);

    rattlesnake_reg_file_mp_dual_port_ram #(
      .ADDR_WIDTH (REG_ADDR_BITS),
      .DATA_WIDTH (XLEN)
    ) u_ram (
      .clk          (clk),
      .write_enable (ram_we),
      .write_addr   (ram_waddr),
      .write_data   (ram_wdata),
      .read_enable  (rd_accept),
      .read_addr    (rd_addr[i]),
      .read_data    (ram_rdata[i])
    );

    // x0 beats forwarding, forwarding beats the (read-first) RAM word.
    assign bus.read_data_out[i*XLEN +: XLEN] = !read_en_out_q ? '0 :
                                               zero_q[i]      ? '0 :
                                               fwd_q[i]       ? fwd_data_q :
                                                                ram_rdata[i];
  end

  assign bus.read_en_out   = read_en_out_q;
  assign bus.init_busy     = (state_q == StInit);
  assign bus.write_dropped = write_dropped_q;

endmodule

// File: doc/rattlesnake_reg_file_mp.md
# rattlesnake_reg_file_mp

Parametrised integer register file for the PulseRain RV2T core. It has N block-RAM read ports, one write port, and write-to-read forwarding. Register 0 is hardwired to zero. A built-in clear sequencer zeroes every entry after reset, because BRAM contents cannot be reset. It sits between decode (read addresses) and write-back (write port), and supports both RV32I (32 entries) and RV32E (16 entries).

## Interface
- XLEN, 32, data width in bits
- REG_ADDR_BITS, 5, address width; DEPTH = 2**REG_ADDR_BITS (4 selects RV32E)
- NUM_READ_PORTS, 2, number of independent read ports (1..4)
- INIT_ON_RESET, 1, 1 = run the clear sequencer after reset/sync_reset; 0 = start in RUN
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- sync_reset  in  1  synchronous reset; same effect as reset_n, applied at the clock edge
- read_enable  in  1  sample all read addresses this cycle
- read_addr  in  NUM_READ_PORTS*REG_ADDR_BITS  packed read addresses; port i = bits [i*REG_ADDR_BITS +: REG_ADDR_BITS]
- read_en_out  out  1  read data valid (one cycle after an accepted read_enable)
- read_data_out  out  NUM_READ_PORTS*XLEN  packed read data; port i = bits [i*XLEN +: XLEN]
- write_enable  in  1  write request
- write_addr  in  REG_ADDR_BITS  write address
- write_data_in  in  XLEN  write data
- init_busy  out  1  clear sequencer active; reads and writes are not accepted
- write_dropped  out  1  sticky flag: a write_enable arrived while init_busy=1; cleared only by reset/sync_reset

## Operation
- FSM states: INIT and RUN.
  - Reset/sync_reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
  - INIT: clr_cnt counts 0..DEPTH-1. Each cycle it writes 0 to address clr_cnt in every port RAM.
  - After the write to DEPTH-1, the FSM moves to RUN. clr_cnt wraps to 0 and stops.
- In INIT:
  - init_busy=1.
  - read_enable is ignored, so read_en_out stays 0.
  - write_enable is ignored and sets write_dropped.
- In RUN:
  - write_enable=1 writes write_data_in to all NUM_READ_PORTS RAM copies at write_addr.
  - A write to address 0 is harmless: reads of address 0 always return 0.
- Read: read_enable=1 in cycle t captures each read_addr[i]. read_data_out[i] is valid in cycle t+1 with read_en_out=1.
- Per-port result mux at t+1, in priority order:
  1. Captured address == 0 -> 0.
  2. Else, if write_enable && write_addr == read_addr[i] at cycle t -> write_data_in from cycle t (forwarded).
  3. Else -> RAM output.
- read_data_out = 0 whenever read_en_out = 0.
- A write in cycle t+1 to an address read at cycle t does not affect the t+1 output. It is visible to reads issued at t+1 or later.

## Timing
- Reset values:
  - read_en_out = 0, read_data_out = 0, write_dropped = 0, clr_cnt = 0.
  - init_busy = INIT_ON_RESET; FSM = INIT if INIT_ON_RESET=1, else RUN.
- Clear duration: with reset released before edge 0, init_busy is high for edges 0..DEPTH-1 and low from edge DEPTH. That is 32 cycles for RV32I, 16 for RV32E.
- Read latency: 1 cycle. Back-to-back reads are accepted every cycle.
- Write latency: 0 visible cycles (write-first forwarding), as described in Operation.
- Reset or sync_reset mid-INIT restarts clearing at address 0.
- Reset or sync_reset mid-RUN:
  - Outputs return to reset values.
  - RAM contents are re-cleared (INIT_ON_RESET=1) or left unchanged (INIT_ON_RESET=0).
  - A read in flight is discarded (read_en_out=0 on the next cycle).
- sync_reset has priority over read_enable and write_enable in the same cycle.

## Structure
- XLEN, REG_ADDR_BITS, and the FSM state encoding belong in the shared common.vh constants.
- Sub-module dual_port_ram (ADDR_WIDTH=REG_ADDR_BITS, DATA_WIDTH=XLEN) is instantiated NUM_READ_PORTS times in a generate loop, all copies sharing one write port.
- Per-port forwarding and zero logic is a generate loop in this module. No further sub-module.
- RAM write port mux: clr_cnt/0 during INIT, write_addr/write_data_in during RUN.

## Test plan
- Reset release with DEPTH=32 -> init_busy high for exactly 32 cycles. A subsequent read of every address returns 0x00000000.
- In RUN, write x5=0xDEADBEEF, then the next cycle read x5 on port 0 and x5 on port 1 -> both ports return 0xDEADBEEF one cycle later with read_en_out=1.
- Same-cycle write x7=0x12345678 and read x7 (old value 0x1) -> the read returns 0x12345678 (forwarded).
- Write x0=0xFFFFFFFF, then read x0 on all ports -> 0. Also check: read_enable=0 -> read_data_out=0 and read_en_out=0.
- write_enable during INIT to x3=0xAA -> write_dropped=1 and stays 1. After INIT, x3 reads 0.
- RV32E configuration (REG_ADDR_BITS=4, NUM_READ_PORTS=3) plus a mid-INIT sync_reset at cycle 8 -> clearing restarts, init_busy falls 16 cycles after the sync_reset edge, and three-port reads of x15 after a write of 0x55 return 0x55 on every port.
